stream_fifo: RTL and testbench



---
 rtl/stream_fifo_pkg.sv | 7 +
 rtl/fifo_mem.sv | 26 ++
 rtl/stream_fifo.sv | 88 ++++++++
 tb/tb_stream_fifo.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/stream_fifo_pkg.sv
// Shared constants for the example_module -> stream_fifo datapath.
// Holds the default data word width both blocks agree on.
package stream_fifo_pkg;

  localparam int DATA_WIDTH = 8;

endpackage

// File: rtl/fifo_mem.sv
// Storage array for stream_fifo: WIDTH x DEPTH, no reset.
// Ports: clk, we/waddr/wdata (sync write), raddr/rdata (async read).
module fifo_mem #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO with sticky overflow flag.
// Ports: clk, rst, clear, in_*, out_*, count, overflow.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int ADDR_BITS = $clog2(DEPTH);
  localparam int CNT_BITS  = $clog2(DEPTH + 1);

  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0]  count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 push, pop;
  logic [WIDTH-1:0]     rd_data;

  // Flags come only from count, so ready never depends on valid.
  assign in_ready  = (count_q != CNT_BITS'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign out_data  = out_valid ? rd_data : '0;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push && !rst && !clear),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_BITS'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_BITS'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_BITS'(1);
    end
    if (in_valid && !in_ready) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo: vector table plus corner sequences.
// Drives inputs after each edge and samples outputs 1ns later.
module tb_stream_fifo;

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  logic       clk = 1'b0;
  logic       rst, clear, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid, overflow;
  logic [7:0] out_data;
  logic [4:0] count;

  int n_cmp = 0;
  int n_err = 0;

  stream_fifo #(.WIDTH(8), .DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         r, c, vl, rd;
    logic [7:0] din;
    logic [4:0] cnt;
    bit         ov, ir, of;
    logic [7:0] dout;
  } vec_t;

  function automatic vec_t mk(bit r, bit c, bit vl, bit rd,
                              logic [7:0] din, logic [4:0] cnt,
                              bit ov, bit ir, bit of,
                              logic [7:0] dout);
    vec_t v;
    v.r = r; v.c = c; v.vl = vl; v.rd = rd; v.din = din;
    v.cnt = cnt; v.ov = ov; v.ir = ir; v.of = of; v.dout = dout;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit c, input bit vl,
                      input bit rd, input logic [7:0] d);
    rst = r; clear = c; in_valid = vl; out_ready = rd; in_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic fill16();
    for (int i = 0; i < 16; i++) step(L, L, H, L, 8'(i));
  endtask

  vec_t tbl[15];

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; in_data = 8'h00;

    //           r  c  vl rd din     cnt    ov ir of dout
    tbl[0]  = mk(H, L, L, L, 8'h00, 5'd0, L, H, L, 8'h00);
    tbl[1]  = mk(H, L, L, L, 8'h00, 5'd0, L, H, L, 8'h00);
    tbl[2]  = mk(L, L, L, L, 8'h00, 5'd0, L, H, L, 8'h00);
    tbl[3]  = mk(L, L, H, L, 8'hAA, 5'd1, H, H, L, 8'hAA);
    tbl[4]  = mk(L, L, L, L, 8'h00, 5'd1, H, H, L, 8'hAA);
    tbl[5]  = mk(L, L, L, H, 8'h00, 5'd0, L, H, L, 8'h00);
    tbl[6]  = mk(L, L, L, H, 8'h00, 5'd0, L, H, L, 8'h00);
    tbl[7]  = mk(L, L, H, H, 8'h11, 5'd1, H, H, L, 8'h11);
    tbl[8]  = mk(L, L, H, H, 8'h22, 5'd1, H, H, L, 8'h22);
    tbl[9]  = mk(L, L, L, H, 8'h00, 5'd0, L, H, L, 8'h00);
    tbl[10] = mk(L, L, H, L, 8'h33, 5'd1, H, H, L, 8'h33);
    tbl[11] = mk(L, L, H, L, 8'h44, 5'd2, H, H, L, 8'h33);
    tbl[12] = mk(L, H, H, H, 8'h99, 5'd0, L, H, L, 8'h00);
    tbl[13] = mk(L, L, H, L, 8'h66, 5'd1, H, H, L, 8'h66);
    tbl[14] = mk(H, L, H, H, 8'h77, 5'd0, L, H, L, 8'h00);

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].r, tbl[i].c, tbl[i].vl, tbl[i].rd, tbl[i].din);
      chk($sformatf("v%0d.count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d.out_valid", i), 32'(out_valid),
          32'(tbl[i].ov));
      chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
      chk($sformatf("v%0d.overflow", i), 32'(overflow), 32'(tbl[i].of));
      chk($sformatf("v%0d.out_data", i), 32'(out_data),
          32'(tbl[i].dout));
    end

    // Fill, overflow, drain in order.
    step(H, L, L, L, 8'h00);
    fill16();
    chk("fill.count", 32'(count), 32'd16);
    chk("fill.in_ready", 32'(in_ready), 32'd0);
    chk("fill.overflow", 32'(overflow), 32'd0);
    step(L, L, H, L, 8'hFF);
    chk("ovf.count", 32'(count), 32'd16);
    chk("ovf.overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d.data", i), 32'(out_data), 32'(i));
      step(L, L, L, H, 8'h00);
    end
    chk("drain.out_valid", 32'(out_valid), 32'd0);
    chk("drain.overflow", 32'(overflow), 32'd1);

    // Push and pop together while full.
    step(H, L, L, L, 8'h00);
    fill16();
    step(L, L, H, H, 8'hEE);
    chk("fullpp.count", 32'(count), 32'd15);
    chk("fullpp.overflow", 32'(overflow), 32'd1);
    chk("fullpp.in_ready", 32'(in_ready), 32'd1);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("fullpp%0d.data", i), 32'(out_data), 32'(i));
      step(L, L, L, H, 8'h00);
    end
    chk("fullpp.empty", 32'(out_valid), 32'd0);

    // Streaming across two pointer wraps.
    step(H, L, L, L, 8'h00);
    for (int k = 1; k <= 40; k++) begin
      step(L, L, H, H, 8'(k));
      chk($sformatf("wrap%0d.data", k), 32'(out_data), 32'(k));
      chk($sformatf("wrap%0d.count", k), 32'(count), 32'd1);
    end
    step(L, L, L, H, 8'h00);
    chk("wrap.count", 32'(count), 32'd0);
    chk("wrap.overflow", 32'(overflow), 32'd0);

    // Clear mid-burst with overflow pending.
    step(H, L, L, L, 8'h00);
    fill16();
    step(L, L, H, L, 8'hFF);
    for (int i = 0; i < 11; i++) step(L, L, L, H, 8'h00);
    chk("pre_clr.count", 32'(count), 32'd5);
    chk("pre_clr.overflow", 32'(overflow), 32'd1);
    step(L, H, H, L, 8'hBB);
    chk("clr.count", 32'(count), 32'd0);
    chk("clr.out_valid", 32'(out_valid), 32'd0);
    chk("clr.overflow", 32'(overflow), 32'd0);
    chk("clr.in_ready", 32'(in_ready), 32'd1);
    step(L, L, H, L, 8'h55);
    chk("post_clr.data", 32'(out_data), 32'h55);
    chk("post_clr.count", 32'(count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
